// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_stage_reg #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            ID_valid,
  input  logic [6:0]      ID_OPcode,
  input  logic [2:0]      ID_ALUOp,
  input  logic            ID_ALUSrcA,
  input  logic [1:0]      ID_ALUSrcB,
  input  logic            ID_RegWrite,
  input  logic [3:0]      ID_D_MEM_BE,
  input  logic            ID_MemWrite,
  input  logic            ID_MemtoReg,
  input  logic            ID_JALR_mul,
  input  logic            ID_inc_NUM_INST,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_rs1_data,
  input  logic [XLEN-1:0] ID_rs2_data,
  input  logic [XLEN-1:0] ID_imm,
  input  logic [RA_W-1:0] ID_rs1,
  input  logic [RA_W-1:0] ID_rs2,
  input  logic [RA_W-1:0] ID_rd,
  input  logic [2:0]      ID_funct3,
  input  logic            ID_funct7b5,
  input  logic            flush,
  output logic            load_use_stall,
  output logic            EX_valid,
  output logic [2:0]      EX_ALUOp,
  output logic            EX_ALUSrcA,
  output logic [1:0]      EX_ALUSrcB,
  output logic            EX_RegWrite,
  output logic [3:0]      EX_D_MEM_BE,
  output logic            EX_MemWrite,
  output logic            EX_MemtoReg,
  output logic            EX_JALR_mul,
  output logic            EX_inc_NUM_INST,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] EX_rs1_data,
  output logic [XLEN-1:0] EX_rs2_data,
  output logic [XLEN-1:0] EX_imm,
  output logic [RA_W-1:0] EX_rs1,
  output logic [RA_W-1:0] EX_rs2,
  output logic [RA_W-1:0] EX_rd,
  output logic [2:0]      EX_funct3,
  output logic            EX_funct7b5,
  output logic [31:0]     bubble_count
);
  logic use_rs1, use_rs2, bubble;
  always_comb begin
    use_rs2 = (ID_OPcode == 7'b0110011) | (ID_OPcode == 7'b1100011) | (ID_OPcode == 7'b0100011);
    use_rs1 = use_rs2 | (ID_OPcode == 7'b0010011) | (ID_OPcode == 7'b0000011) | (ID_OPcode == 7'b1100111);
  end
  assign load_use_stall = ID_valid & ~flush & EX_valid & EX_MemtoReg & (EX_rd != '0) &
                          ((use_rs1 & (ID_rs1 == EX_rd)) | (use_rs2 & (ID_rs2 == EX_rd)));
  assign bubble = flush | load_use_stall | ~ID_valid;
  // Control fields are squashed on a bubble so the EX instruction has no side effects.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      EX_valid        <= 1'b0;
      EX_ALUOp        <= '0;
      EX_RegWrite     <= 1'b0;
      EX_D_MEM_BE     <= '0;
      EX_MemWrite     <= 1'b1;
      EX_MemtoReg     <= 1'b0;
      EX_JALR_mul     <= 1'b0;
      EX_inc_NUM_INST <= 1'b0;
    end else begin
      EX_valid        <= ~bubble;
      EX_ALUOp        <= bubble ? 3'b000 : ID_ALUOp;
      EX_RegWrite     <= bubble ? 1'b0 : ID_RegWrite;
      EX_D_MEM_BE     <= bubble ? 4'b0000 : ID_D_MEM_BE;
      EX_MemWrite     <= bubble ? 1'b1 : ID_MemWrite;
      EX_MemtoReg     <= bubble ? 1'b0 : ID_MemtoReg;
      EX_JALR_mul     <= bubble ? 1'b0 : ID_JALR_mul;
      EX_inc_NUM_INST <= bubble ? 1'b0 : ID_inc_NUM_INST;
    end
  end
  // Data fields simply hold across bubbles.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      EX_ALUSrcA  <= 1'b0;
      EX_ALUSrcB  <= '0;
      EX_PC       <= '0;
      EX_rs1_data <= '0;
      EX_rs2_data <= '0;
      EX_imm      <= '0;
      EX_rs1      <= '0;
      EX_rs2      <= '0;
      EX_rd       <= '0;
      EX_funct3   <= '0;
      EX_funct7b5 <= 1'b0;
    end else if (!bubble) begin
      EX_ALUSrcA  <= ID_ALUSrcA;
      EX_ALUSrcB  <= ID_ALUSrcB;
      EX_PC       <= ID_PC;
      EX_rs1_data <= ID_rs1_data;
      EX_rs2_data <= ID_rs2_data;
      EX_imm      <= ID_imm;
      EX_rs1      <= ID_rs1;
      EX_rs2      <= ID_rs2;
      EX_rd       <= ID_rd;
      EX_funct3   <= ID_funct3;
      EX_funct7b5 <= ID_funct7b5;
    end
  end
`ifdef ID_EX_BUBBLE_COUNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) bubble_count <= '0;
    else if (bubble) bubble_count <= bubble_count + 32'd1;
  end
`else
  assign bubble_count = '0;
`endif
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the instruction decoder in the 5-stage RISC-V pipeline CPU.
- Latches the decoded control bundle plus operands, PC, immediate and register addresses into the EX stage.
- Detects load-use hazards and inserts bubbles; branch/jump flushes from EX also become bubbles.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
RA_W, 5, register-file address width

Ports:
CLK  input  1  pipeline clock, rising edge
RSTn  input  1  asynchronous active-low reset
ID_valid  input  1  ID stage holds a real instruction
ID_OPcode  input  7  opcode of ID instruction (for operand-use decode)
ID_ALUOp  input  3  decoder ALUOp
ID_ALUSrcA  input  1  decoder ALUSrcA
ID_ALUSrcB  input  2  decoder ALUSrcB
ID_RegWrite  input  1  decoder RegWrite
ID_D_MEM_BE  input  4  decoder byte enables
ID_MemWrite  input  1  decoder D-mem write enable, active-low (1 = no write)
ID_MemtoReg  input  1  decoder MemtoReg
ID_JALR_mul  input  1  decoder JALR select
ID_inc_NUM_INST  input  1  decoder increment_NUM_INST
ID_PC, ID_rs1_data, ID_rs2_data, ID_imm  input  XLEN each  PC, operands, sign-extended immediate
ID_rs1, ID_rs2, ID_rd  input  RA_W each  register addresses
ID_funct3  input  3  funct3
ID_funct7b5  input  1  instr[30]
flush  input  1  EX redirect (taken branch/JAL/JALR); kill ID instruction
load_use_stall  output  1  combinational: hold PC and IF/ID this cycle
EX_valid  output  1  EX holds a real instruction
EX_* (one per ID_* field above except ID_valid, ID_OPcode)  output  same widths  registered copies
bubble_count  output  32  bubbles inserted (see Optional Feature)

Behaviour:
- All EX_* registers update on posedge CLK; cleared asynchronously on negedge RSTn.
- Reset values: all EX_* 0, except EX_MemWrite = 1 and EX_valid = 0; bubble_count = 0.
- Operand-use decode from ID_OPcode:
  - R-type 0110011, Branch 1100011, SW 0100011: use rs1 and rs2.
  - I-type 0010011, LW 0000011, JALR 1100111: use rs1 only.
  - JAL 1101111 and all other opcodes: use neither.
- load_use_stall = ID_valid & !flush & EX_valid & EX_MemtoReg & (EX_rd != 0) & ((use_rs1 & ID_rs1 == EX_rd) | (use_rs2 & ID_rs2 == EX_rd)).
- Per-edge priority:
  1. flush → bubble.
  2. load_use_stall → bubble; ID contents are not lost, because upstream holds them.
  3. !ID_valid → bubble.
  4. Otherwise capture all ID_* fields and set EX_valid = 1.
- Bubble: EX_valid = 0, EX_RegWrite = 0, EX_D_MEM_BE = 0000, EX_MemWrite = 1, EX_MemtoReg = 0, EX_JALR_mul = 0, EX_inc_NUM_INST = 0, EX_ALUOp = 000. Data fields (PC, operands, imm, addresses) keep their previous values.
- Latency: one cycle ID→EX. A load followed by a dependent instruction costs exactly one bubble; the next cycle EX holds the bubble, so the stall deasserts.
- rd = x0 never triggers a stall. Flush and hazard in the same cycle: flush wins and load_use_stall is 0.
- RSTn asserted mid-stall: bubble state immediately; load_use_stall drops to 0 (EX_valid = 0).

Optional Feature:
Macro ID_EX_BUBBLE_COUNT_EN.
- Defined: bubble_count increments by 1 on every edge that loads a bubble while RSTn is high, for any cause. It wraps from FFFFFFFF to 0.
- Undefined: no counter register; bubble_count is tied to 0.

Test Plan:
- Reset: RSTn = 0 for 2 cycles, then release → EX_valid = 0, EX_MemWrite = 1, EX_RegWrite = 0, load_use_stall = 0.
- Normal capture: ID ADDI x5,x1,7 (OPcode 0010011, ID_imm = 7, PC = 0x10), ID_valid = 1 → next edge EX_rd = 5, EX_imm = 7, EX_PC = 0x10, EX_ALUOp = 001, EX_valid = 1.
- Load-use: EX = LW x6; ID = ADD x7,x6,x2 → load_use_stall = 1 for one cycle; next edge bubble in EX; following edge ADD captured. bubble_count = 1 with the macro defined.
- x0 and non-use: EX = LW x0, ID = ADD x1,x0,x0 → no stall. EX = LW x6, ID = JAL x6 → no stall.
- Flush priority: flush = 1 together with a load-use condition → load_use_stall = 0, bubble captured, EX_D_MEM_BE = 0000.
- SW rs2 hazard: EX = LW x9, ID = SW x9,0(x3) → stall asserted. With the macro undefined, bubble_count stays 0.
